// File: rtl/gradient_magnitude_pipe.sv
// -----------------------------------------------------------------------------
// gradient_magnitude_pipe
//
// Three-stage pipelined gradient-magnitude stage for the Sobel edge path.
// Converts a signed Gx/Gy pair into an unsigned magnitude, saturates it to
// OUT_W bits and hands it downstream over a valid/ready handshake. A per-frame
// count of saturated pixels is kept for threshold tuning.
//
//   S1 : |gx|, |gy|            (IN_W bits unsigned, -2^(IN_W-1) does not wrap)
//   S2 : combined magnitude    (IN_W+1 bits unsigned)
//   S3 : saturated g, sat flag (OUT_W bits)
//
// Parameters
//   IN_W  : width of signed gx/gy (two's complement)
//   OUT_W : width of unsigned g; saturation ceiling 2^OUT_W-1 (OUT_W <= IN_W)
//   MODE  : 0 = |gx|+|gy|, 1 = max + (min>>1)
//   CNT_W : width of the saturated-pixel counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active low
//   in_valid   in   gx/gy/in_sof valid
//   in_ready   out  stage accepts input this cycle (combinational)
//   in_sof     in   first pixel of frame
//   gx, gy     in   signed gradients
//   out_valid  out  g/out_sof valid
//   out_ready  in   downstream accepts
//   out_sof    out  delayed in_sof
//   g          out  saturated magnitude
//   sat_count  out  saturated pixels transferred in the current frame
//
// Optional build macro GRAD_THRESHOLD_EN adds:
//   thresh     in   edge threshold (quasi-static)
//   edge_o     out  registered (g >= thresh), aligned with g
// -----------------------------------------------------------------------------
module gradient_magnitude_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic signed [IN_W-1:0] gx,
  input  logic signed [IN_W-1:0] gy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic [OUT_W-1:0]       g,
  output logic [CNT_W-1:0]       sat_count
`ifdef GRAD_THRESHOLD_EN
  ,
  input  logic [OUT_W-1:0]       thresh,
  output logic                   edge_o
`endif
);

  localparam logic [IN_W:0] G_MAX = {{(IN_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic              adv;

  logic [IN_W-1:0]   ax_d, ay_d;
  logic              s1_valid_q, s1_sof_q;
  logic [IN_W-1:0]   s1_ax_q, s1_ay_q;

  logic [IN_W-1:0]   mx_d, mn_d;
  logic [IN_W:0]     mag_d;
  logic              s2_valid_q, s2_sof_q;
  logic [IN_W:0]     s2_mag_q;

  logic              sat_d;
  logic [OUT_W-1:0]  g_d;
  logic              s3_valid_q, s3_sof_q, s3_sat_q;
  logic [OUT_W-1:0]  s3_g_q;

  logic [CNT_W-1:0]  cnt_d, cnt_q;

`ifdef GRAD_THRESHOLD_EN
  logic              edge_d, edge_q;
`endif

  // Two's-complement magnitude reinterpreted as unsigned, so the most
  // negative input maps to 2^(IN_W-1) instead of wrapping.
  function automatic logic [IN_W-1:0] abs_u(input logic [IN_W-1:0] v);
    return v[IN_W-1] ? (~v + IN_W'(1)) : v;
  endfunction

  // A single advance for the whole pipe: bubbles are never squeezed out,
  // which keeps the stall behaviour trivially order-preserving.
  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1
  always_comb begin
    ax_d = abs_u(gx);
    ay_d = abs_u(gy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_ax_q    <= '0;
      s1_ay_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_sof_q   <= in_valid && in_sof;
      s1_ax_q    <= ax_d;
      s1_ay_q    <= ay_d;
    end
  end

  // ---------------------------------------------------------------- S2
  always_comb begin
    mx_d = (s1_ax_q >= s1_ay_q) ? s1_ax_q : s1_ay_q;
    mn_d = (s1_ax_q >= s1_ay_q) ? s1_ay_q : s1_ax_q;
    if (MODE == 1) begin
      // min>>1 truncates toward zero
      mag_d = {1'b0, mx_d} + {2'b00, mn_d[IN_W-1:1]};
    end else begin
      mag_d = {1'b0, s1_ax_q} + {1'b0, s1_ay_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_mag_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      s2_mag_q   <= mag_d;
    end
  end

  // ---------------------------------------------------------------- S3
  always_comb begin
    sat_d = (s2_mag_q > G_MAX);
    g_d   = sat_d ? {OUT_W{1'b1}} : s2_mag_q[OUT_W-1:0];
`ifdef GRAD_THRESHOLD_EN
    edge_d = (g_d >= thresh);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sof_q   <= 1'b0;
      s3_sat_q   <= 1'b0;
      s3_g_q     <= '0;
`ifdef GRAD_THRESHOLD_EN
      edge_q     <= 1'b0;
`endif
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_sof_q   <= s2_sof_q;
      s3_sat_q   <= sat_d;
      s3_g_q     <= g_d;
`ifdef GRAD_THRESHOLD_EN
      edge_q     <= edge_d;
`endif
    end
  end

  // ------------------------------------------------- saturated-pixel count
  // Counted on transfer, not on S3 load, so a stalled beat counts once.
  // A start-of-frame beat restarts the count including itself.
  always_comb begin
    cnt_d = cnt_q;
    if (s3_valid_q && out_ready) begin
      if (s3_sof_q) begin
        cnt_d = CNT_W'(s3_sat_q);
      end else if (s3_sat_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_sof   = s3_sof_q;
  assign g         = s3_g_q;
  assign sat_count = cnt_q;
`ifdef GRAD_THRESHOLD_EN
  assign edge_o    = edge_q;
`endif

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// Scoreboard bench for gradient_magnitude_pipe. Two instances: u0 in MODE 0
// with the default counter, u1 in MODE 1 with a 2-bit counter so that counter
// saturation is reachable. Expected values are hand-computed in the calls.
module tb_gradient_magnitude_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic              in_sof    [2];
  logic signed [10:0] gx       [2];
  logic signed [10:0] gy       [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic              out_sof   [2];
  logic [7:0]        g         [2];
  logic [19:0]       sc0;
  logic [1:0]        sc1;
  logic [1:0]        edge_v;
  logic [7:0]        thresh;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gradient_magnitude_pipe #(.IN_W(11), .OUT_W(8), .MODE(0), .CNT_W(20)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_sof(in_sof[0]), .gx(gx[0]), .gy(gy[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sof(out_sof[0]), .g(g[0]), .sat_count(sc0)
`ifdef GRAD_THRESHOLD_EN
    , .thresh(thresh), .edge_o(edge_v[0])
`endif
  );

  gradient_magnitude_pipe #(.IN_W(11), .OUT_W(8), .MODE(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_sof(in_sof[1]), .gx(gx[1]), .gy(gy[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sof(out_sof[1]), .g(g[1]), .sat_count(sc1)
`ifdef GRAD_THRESHOLD_EN
    , .thresh(thresh), .edge_o(edge_v[1])
`endif
  );

`ifndef GRAD_THRESHOLD_EN
  assign edge_v = 2'b00;
`endif

  typedef struct packed {
    logic [7:0]  g;
    logic        sat;
    logic        sof;
    logic        lat;
    logic [31:0] acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ------------------------------------------------------------- monitor
  logic        pstall [2];
  logic [7:0]  pg     [2];
  logic        psof   [2];
  logic [19:0] ecnt   [2];

  task automatic mon(input int k, input logic [19:0] sc, input logic [19:0] cmax, input logic e_act);
    exp_t e;
    chk($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'(!out_valid[k] || out_ready[k]));
    chk($sformatf("sat_count%0d", k), 32'(sc), 32'(ecnt[k]));
    if (pstall[k]) begin
      chk($sformatf("hold_valid%0d", k), 32'(out_valid[k]), 32'd1);
      chk($sformatf("hold_g%0d", k), 32'(g[k]), 32'(pg[k]));
      chk($sformatf("hold_sof%0d", k), 32'(out_sof[k]), 32'(psof[k]));
    end
    pstall[k] = out_valid[k] && !out_ready[k];
    pg[k]     = g[k];
    psof[k]   = out_sof[k];
    if (out_valid[k] === 1'b1 && out_ready[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        fail_now($sformatf("unexpected_output%0d g=%0d", k, g[k]));
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("g%0d", k), 32'(g[k]), 32'(e.g));
        chk($sformatf("out_sof%0d", k), 32'(out_sof[k]), 32'(e.sof));
        if (e.lat) chk($sformatf("latency%0d", k), 32'(cyc) - e.acc, 32'd3);
`ifdef GRAD_THRESHOLD_EN
        chk($sformatf("edge%0d", k), 32'(e_act), 32'(e.g >= thresh));
`endif
        if (e.sof) ecnt[k] = 20'(e.sat);
        else if (e.sat && ecnt[k] != cmax) ecnt[k] = ecnt[k] + 20'd1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        pstall[k] = 1'b0;
        ecnt[k]   = '0;
      end
    end else begin
      mon(0, sc0, 20'hFFFFF, edge_v[0]);
      mon(1, {18'd0, sc1}, 20'd3, edge_v[1]);
    end
  end

  // ------------------------------------------------------------ stimulus
  // Entered and left just after a rising edge, so calls chain back-to-back.
  task automatic send(input int k, input int x, input int y, input bit sof,
                      input int eg, input bit esat, input bit lat);
    exp_t e;
    int   t;
    in_valid[k] = 1'b1;
    gx[k]       = x[10:0];
    gy[k]       = y[10:0];
    in_sof[k]   = sof;
    t = 0;
    @(negedge clk);
    while (!in_ready[k] && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) fail_now($sformatf("in_ready_timeout%0d", k));
    e.g = eg[7:0]; e.sat = esat; e.sof = sof; e.lat = lat; e.acc = 32'(cyc);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_sof[k]   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while ((q0.size() != 0 || q1.size() != 0) && t < 300);
    #1;
    if (t >= 300) fail_now("drain_timeout");
  endtask

  typedef struct { int x; int y; int eg; bit sat; } vec_t;

  vec_t bnd [7] = '{
    '{-128,  127, 255, 1'b0},   // exactly the ceiling: not saturated
    '{ 128,  128, 255, 1'b1},
    '{1023,-1024, 255, 1'b1},
    '{   0,    0,   0, 1'b0},
    '{ 127,    0, 127, 1'b0},
    '{ 128,    0, 128, 1'b0},
    '{1023, 1023, 255, 1'b1}
  };

  vec_t strm [8] = '{
    '{  10,   20,  30, 1'b0},
    '{  -5,   -6,  11, 1'b0},
    '{ 200,  100, 255, 1'b1},
    '{   0, -255, 255, 1'b0},
    '{   1,    1,   2, 1'b0},
    '{-512,  512, 255, 1'b1},
    '{  63,   64, 127, 1'b0},
    '{  -7,    0,   7, 1'b0}
  };

  vec_t m1 [8] = '{
    '{-200,   60, 230, 1'b0},
    '{   5,    3,   6, 1'b0},
    '{   3,    5,   6, 1'b0},
    '{   7,    7,  10, 1'b0},
    '{-1024,   0, 255, 1'b1},
    '{1023, 1023, 255, 1'b1},
    '{  -1,-1024, 255, 1'b1},
    '{ 600, -600, 255, 1'b1}
  };

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    thresh = 8'd128;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_sof[k] = 1'b0; gx[k] = '0; gy[k] = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_g%0d", k), 32'(g[k]), 32'd0);
      chk($sformatf("rst_sof%0d", k), 32'(out_sof[k]), 32'd0);
    end
    chk("rst_cnt0", 32'(sc0), 32'd0);
    chk("rst_cnt1", 32'(sc1), 32'd0);

    // single pixel, latency, non-saturating start of frame
    send(0, 100, -50, 1'b1, 150, 1'b0, 1'b1);
    drain();
    chk("cnt_after_150", 32'(sc0), 32'd0);

    // most negative inputs, saturating start of frame
    send(0, -1024, -1024, 1'b1, 255, 1'b1, 1'b1);
    drain();
    chk("cnt_after_sof_sat", 32'(sc0), 32'd1);

    // boundaries back-to-back at full throughput
    foreach (bnd[i]) send(0, bnd[i].x, bnd[i].y, 1'b0, bnd[i].eg, bnd[i].sat, 1'b1);
    drain();
    chk("cnt_after_bnd", 32'(sc0), 32'd4);

    // backpressure stream
    fork
      begin
        foreach (strm[i]) send(0, strm[i].x, strm[i].y, 1'b0, strm[i].eg, strm[i].sat, 1'b0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready[0] = pat[i % 4];
          @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
      end
    join
    drain();
    chk("cnt_after_stream", 32'(sc0), 32'd6);

    // reset with three pixels in flight
    out_ready[0] = 1'b0;
    send(0, 10, 10, 1'b0, 20, 1'b0, 1'b0);
    send(0, 1000, 1000, 1'b0, 255, 1'b1, 1'b0);
    send(0, 30, 30, 1'b0, 60, 1'b0, 1'b0);
    chk("stall_full", 32'(out_valid[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_g", 32'(g[0]), 32'd0);
    chk("mid_rst_cnt", 32'(sc0), 32'd0);
    out_ready[0] = 1'b1;
    send(0, -3, 4, 1'b0, 7, 1'b0, 1'b1);
    drain();

    // MODE 1 and counter saturation on the 2-bit counter
    send(1, m1[0].x, m1[0].y, 1'b1, m1[0].eg, m1[0].sat, 1'b1);
    for (int i = 1; i < 8; i++) send(1, m1[i].x, m1[i].y, 1'b0, m1[i].eg, m1[i].sat, 1'b1);
    drain();
    chk("cnt1_saturated", 32'(sc1), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
